// File: rtl/rename_pkg.sv
// Shared rename/retire constants, register index type and pointer helper.
// ptr_add_mod48 advances a free-list pointer with exact wrap at FL_DEPTH.
package rename_pkg;

  localparam int NUM_PHYS_REGS = 80;
  localparam int NUM_ARCH_REGS = 32;
  localparam int FL_DEPTH      = 48;
  localparam int PRD_W         = 7;
  localparam int RET_W         = 4;
  localparam int PTR_W         = 6;

  typedef logic [PRD_W-1:0] prd_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    REC_IDLE = 1'b0,
    REC_BUSY = 1'b1
  } rec_state_t;

  // Both operands are below 48, so one conditional subtract suffices.
  function automatic ptr_t ptr_add_mod48(input ptr_t ptr, input ptr_t inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + {1'b0, inc};
    if (sum >= (PTR_W+1)'(FL_DEPTH))
      sum = sum - (PTR_W+1)'(FL_DEPTH);
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/arch_rfl_mem.sv
// Committed free-list storage: 48 x 7 array, 4 read / 4 write ports.
// Ports: head, rd_idx/rd_data, wr_en/wr_idx/wr_data, dump (rotated by head).
module arch_rfl_mem
  import rename_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  ptr_t                      head,
  input  ptr_t                      rd_idx  [RET_W],
  output prd_t                      rd_data [RET_W],
  input  logic [RET_W-1:0]          wr_en,
  input  ptr_t                      wr_idx  [RET_W],
  input  prd_t                      wr_data [RET_W],
  output logic [FL_DEPTH*PRD_W-1:0] dump
);

  prd_t mem [FL_DEPTH];

  // Active slots always target distinct entries, so write order is moot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++)
        mem[i] <= prd_t'(NUM_ARCH_REGS + i);
    end else begin
      for (int k = 0; k < RET_W; k++)
        if (wr_en[k])
          mem[wr_idx[k]] <= wr_data[k];
    end
  end

  always_comb begin
    for (int k = 0; k < RET_W; k++)
      rd_data[k] = mem[rd_idx[k]];
  end

  // Slice i holds the entry i places after head, i.e. oldest first.
  always_comb begin
    dump = '0;
    for (int i = 0; i < FL_DEPTH; i++)
      dump[i*PRD_W +: PRD_W] = mem[ptr_add_mod48(head, ptr_t'(i))];
  end

endmodule

// File: rtl/arch_rfl.sv
// Retire-side architectural free list with release forwarding and recovery.
// Ports: retireN_* in, flush_i, rlsN_rd_o/_vld_o, arch_fl_rec_o/_data_o, fl_err_o.
module arch_rfl
  import rename_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      retire0_vld_i,
  input  logic                      retire0_has_rd_i,
  input  logic [PRD_W-1:0]          retire0_new_prd_i,
  input  logic [PRD_W-1:0]          retire0_old_prd_i,
  input  logic                      retire1_vld_i,
  input  logic                      retire1_has_rd_i,
  input  logic [PRD_W-1:0]          retire1_new_prd_i,
  input  logic [PRD_W-1:0]          retire1_old_prd_i,
  input  logic                      retire2_vld_i,
  input  logic                      retire2_has_rd_i,
  input  logic [PRD_W-1:0]          retire2_new_prd_i,
  input  logic [PRD_W-1:0]          retire2_old_prd_i,
  input  logic                      retire3_vld_i,
  input  logic                      retire3_has_rd_i,
  input  logic [PRD_W-1:0]          retire3_new_prd_i,
  input  logic [PRD_W-1:0]          retire3_old_prd_i,
  input  logic                      flush_i,
  output logic [PRD_W-1:0]          rls0_rd_o,
  output logic                      rls0_rd_vld_o,
  output logic [PRD_W-1:0]          rls1_rd_o,
  output logic                      rls1_rd_vld_o,
  output logic [PRD_W-1:0]          rls2_rd_o,
  output logic                      rls2_rd_vld_o,
  output logic [PRD_W-1:0]          rls3_rd_o,
  output logic                      rls3_rd_vld_o,
  output logic                      arch_fl_rec_o,
  output logic [FL_DEPTH*PRD_W-1:0] arch_fl_rec_data_o,
  output logic                      fl_err_o
);

  logic [RET_W-1:0] vld;
  logic [RET_W-1:0] has_rd;
  prd_t             new_prd [RET_W];
  prd_t             old_prd [RET_W];

  assign vld    = {retire3_vld_i, retire2_vld_i,
                   retire1_vld_i, retire0_vld_i};
  assign has_rd = {retire3_has_rd_i, retire2_has_rd_i,
                   retire1_has_rd_i, retire0_has_rd_i};

  assign new_prd[0] = retire0_new_prd_i;
  assign new_prd[1] = retire1_new_prd_i;
  assign new_prd[2] = retire2_new_prd_i;
  assign new_prd[3] = retire3_new_prd_i;
  assign old_prd[0] = retire0_old_prd_i;
  assign old_prd[1] = retire1_old_prd_i;
  assign old_prd[2] = retire2_old_prd_i;
  assign old_prd[3] = retire3_old_prd_i;

  rec_state_t state;
  rec_state_t state_nxt;
  logic       rec_pulse;
  ptr_t       head;
  ptr_t       head_nxt;
  logic       err;

  logic [RET_W-1:0] active;
  logic [RET_W-1:0] bad;
  logic [2:0]       total;
  ptr_t             pos     [RET_W];
  prd_t             rd_data [RET_W];
  prd_t             rls_rd  [RET_W];
  logic [RET_W-1:0] rls_vld;

  // Retires arriving during recovery are dropped entirely.
  assign active = vld & has_rd & {RET_W{state == REC_IDLE}};

  // Prefix count compacts active slots onto consecutive list positions.
  always_comb begin
    total = '0;
    for (int k = 0; k < RET_W; k++) begin
      pos[k] = ptr_add_mod48(head, ptr_t'(total));
      total  = total + 3'(active[k]);
    end
  end

  assign head_nxt = ptr_add_mod48(head, ptr_t'(total));

  always_comb begin
    for (int k = 0; k < RET_W; k++)
      bad[k] = active[k] & (rd_data[k] != new_prd[k]);
  end

  arch_rfl_mem u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .head    (head),
    .rd_idx  (pos),
    .rd_data (rd_data),
    .wr_en   (active),
    .wr_idx  (pos),
    .wr_data (old_prd),
    .dump    (arch_fl_rec_data_o)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      err  <= 1'b0;
    end else begin
      head <= head_nxt;
      err  <= err | (|bad);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rls_vld <= '0;
      for (int k = 0; k < RET_W; k++)
        rls_rd[k] <= '0;
    end else begin
      rls_vld <= active;
      for (int k = 0; k < RET_W; k++)
        rls_rd[k] <= active[k] ? old_prd[k] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= REC_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rec_pulse = 1'b0;
    unique case (state)
      REC_IDLE: begin
        if (flush_i)
          state_nxt = REC_BUSY;
      end
      REC_BUSY: begin
        rec_pulse = 1'b1;
        state_nxt = flush_i ? REC_BUSY : REC_IDLE;
      end
      default: state_nxt = REC_IDLE;
    endcase
  end

  always @(posedge clock) begin
    if (reset_n && state == REC_BUSY)
      assert (!(|vld))
      else $warning("arch_rfl: retire during recovery ignored");
  end

  assign arch_fl_rec_o = rec_pulse;
  assign fl_err_o      = err;

  assign rls0_rd_o     = rls_rd[0];
  assign rls1_rd_o     = rls_rd[1];
  assign rls2_rd_o     = rls_rd[2];
  assign rls3_rd_o     = rls_rd[3];
  assign rls0_rd_vld_o = rls_vld[0];
  assign rls1_rd_vld_o = rls_vld[1];
  assign rls2_rd_vld_o = rls_vld[2];
  assign rls3_rd_vld_o = rls_vld[3];

endmodule

// File: tb/tb_arch_rfl.sv
// Directed bench for arch_rfl: reset image, retire, wrap, error, recovery.
// Expected values are hand-computed constants.
module tb_arch_rfl;
  import rename_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] vld;
  logic [3:0] has_rd;
  logic [6:0] np [4];
  logic [6:0] op [4];
  logic flush;
  logic [6:0] rls_rd [4];
  logic [3:0] rls_vld;
  logic rec;
  logic [335:0] rec_data;
  logic err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  arch_rfl dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .retire0_vld_i      (vld[0]),
    .retire0_has_rd_i   (has_rd[0]),
    .retire0_new_prd_i  (np[0]),
    .retire0_old_prd_i  (op[0]),
    .retire1_vld_i      (vld[1]),
    .retire1_has_rd_i   (has_rd[1]),
    .retire1_new_prd_i  (np[1]),
    .retire1_old_prd_i  (op[1]),
    .retire2_vld_i      (vld[2]),
    .retire2_has_rd_i   (has_rd[2]),
    .retire2_new_prd_i  (np[2]),
    .retire2_old_prd_i  (op[2]),
    .retire3_vld_i      (vld[3]),
    .retire3_has_rd_i   (has_rd[3]),
    .retire3_new_prd_i  (np[3]),
    .retire3_old_prd_i  (op[3]),
    .flush_i            (flush),
    .rls0_rd_o          (rls_rd[0]),
    .rls0_rd_vld_o      (rls_vld[0]),
    .rls1_rd_o          (rls_rd[1]),
    .rls1_rd_vld_o      (rls_vld[1]),
    .rls2_rd_o          (rls_rd[2]),
    .rls2_rd_vld_o      (rls_vld[2]),
    .rls3_rd_o          (rls_rd[3]),
    .rls3_rd_vld_o      (rls_vld[3]),
    .arch_fl_rec_o      (rec),
    .arch_fl_rec_data_o (rec_data),
    .fl_err_o           (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sl(input int i);
    return 32'(rec_data[i*7 +: 7]);
  endfunction

  task automatic idle_in();
    vld = '0;
    has_rd = '0;
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      np[k] = '0;
      op[k] = '0;
    end
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic slot(input int k, input int n, input int o);
    vld[k] = 1'b1;
    has_rd[k] = 1'b1;
    np[k] = 7'(n);
    op[k] = 7'(o);
  endtask

  // Apply current inputs across one edge, then clear them.
  task automatic step();
    @(posedge clock);
    #1;
    idle_in();
  endtask

  initial begin
    idle_in();
    do_reset();

    chk("rst_slice0", sl(0), 32);
    chk("rst_slice47", sl(47), 79);
    chk("rst_err", 32'(err), 0);
    chk("rst_rls_vld", 32'(rls_vld), 0);
    chk("rst_rec", 32'(rec), 0);

    slot(0, 32, 5);
    step();
    chk("s0_rls0", 32'(rls_rd[0]), 5);
    chk("s0_vld", 32'(rls_vld), 32'h1);
    chk("s0_head1", sl(0), 33);
    chk("s0_entry0", sl(47), 5);
    chk("s0_err", 32'(err), 0);
    step();
    chk("s0_vld_drop", 32'(rls_vld), 0);

    do_reset();
    slot(1, 32, 7);
    slot(3, 33, 9);
    step();
    chk("sp_vld", 32'(rls_vld), 32'hA);
    chk("sp_rls1", 32'(rls_rd[1]), 7);
    chk("sp_rls3", 32'(rls_rd[3]), 9);
    chk("sp_rls0", 32'(rls_rd[0]), 0);
    chk("sp_head2", sl(0), 34);
    chk("sp_entry0", sl(46), 7);
    chk("sp_entry1", sl(47), 9);

    for (int c = 0; c < 11; c++) begin
      for (int k = 0; k < 4; k++)
        slot(k, 34 + 4*c + k, 34 + 4*c + k);
      step();
    end
    chk("adv_head46", sl(0), 78);
    chk("adv_err", 32'(err), 0);

    slot(0, 78, 100);
    slot(1, 79, 101);
    slot(2, 7, 102);
    slot(3, 9, 103);
    step();
    chk("wrap_head2", sl(0), 34);
    chk("wrap_e46", sl(44), 100);
    chk("wrap_e47", sl(45), 101);
    chk("wrap_e0", sl(46), 102);
    chk("wrap_e1", sl(47), 103);
    chk("wrap_vld", 32'(rls_vld), 32'hF);
    chk("wrap_err", 32'(err), 0);

    do_reset();
    slot(0, 40, 5);
    step();
    chk("err_set", 32'(err), 1);
    chk("err_push", sl(47), 5);
    step();
    step();
    chk("err_sticky", 32'(err), 1);

    do_reset();
    chk("err_clr", 32'(err), 0);
    slot(0, 32, 12);
    flush = 1'b1;
    step();
    chk("rec_pulse", 32'(rec), 1);
    chk("rec_s47", sl(47), 12);
    chk("rec_s0", sl(0), 33);
    slot(0, 33, 50);
    step();
    chk("rec_one", 32'(rec), 0);
    chk("rec_nohead", sl(0), 33);
    chk("rec_norls", 32'(rls_vld), 0);
    chk("rec_noerr", 32'(err), 0);

    flush = 1'b1;
    step();
    chk("rec2_pulse", 32'(rec), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rec2_rst", 32'(rec), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
    chk("rec2_idle", 32'(rec), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arch_rfl.md
Name: arch_rfl

Overview:
- Architectural (retirement) free register list; the retire-side counterpart of the speculative free list in rename.
- Sits in the retire stage. Per retiring instruction with a destination:
  - consumes that instruction's new physical register from its head;
  - appends the instruction's old physical register at its tail;
  - forwards the released register to the speculative list.
- On a branch-mispredict flush it drives the whole committed free list, oldest first, so the speculative list can be resynchronised.

Parameters:
- RET_W, 4, retire slots per cycle
- FL_DEPTH, 48, free list entries (NUM_PHYS_REGS - NUM_ARCH_REGS)
- PRD_W, 7, physical register index width

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- retireN_vld_i (N=0..3)  in  1  slot N retiring this cycle
- retireN_has_rd_i  in  1  slot N writes a destination register
- retireN_new_prd_i  in  7  physical reg allocated to slot N at rename
- retireN_old_prd_i  in  7  previous mapping of slot N's arch dest; freed now
- flush_i  in  1  mispredicted branch retires this cycle; request recovery
- rlsN_rd_o (N=0..3)  out  7  released register to the speculative list
- rlsN_rd_vld_o  out  1  rlsN_rd_o valid
- arch_fl_rec_o  out  1  recovery pulse to the speculative list
- arch_fl_rec_data_o  out  336  committed free list; slice i = bits [7i+6:7i] = entry (head+i) mod 48
- fl_err_o  out  1  sticky consistency error

Behaviour:
- Storage: 48 x 7 circular array plus a 6-bit head pointer.
  - Every retire with a destination pops one entry and pushes one, so occupancy is constantly 48 and tail == head.
  - No count register; no full or empty state.
- Reset (asynchronous):
  - entry i = 32+i (regs 32..79), head = 0;
  - all rls*_vld_o = 0, arch_fl_rec_o = 0, fl_err_o = 0;
  - rec data reflects the reset contents.
- Active slot k: retirek_vld_i & retirek_has_rd_i. Slots need not be contiguous.
  - Let p(k) = number of active slots below k.
  - Slot k uses position q = (head + p(k)) mod 48.
  - Check: retirek_new_prd_i must equal mem[q]. On mismatch fl_err_o sets next edge and stays set until reset; the update proceeds regardless.
  - Write: mem[q] <= retirek_old_prd_i.
  - head <= (head + active count) mod 48. Wrap 47 -> 0 must be exact; 6-bit modulo-48 arithmetic, no power-of-2 masking.
- Release forwarding: registered, 1-cycle latency.
  - At edge T+1: rlsk_rd_o <= retirek_old_prd_i and rlsk_rd_vld_o <= active(k), using slot positions (not compacted).
  - Inactive slots drive rd = 0.
- Recovery FSM, states IDLE and REC:
  - IDLE -> REC on flush_i. Retire inputs in the flush cycle are still applied.
  - In REC, arch_fl_rec_o = 1 for exactly one cycle. arch_fl_rec_data_o shows state after the flush-cycle update.
  - REC -> IDLE, or REC -> REC if flush_i is asserted again.
  - retire*_vld_i during REC is illegal: it is ignored (no pop/push, no release) and flagged by assertion.
- arch_fl_rec_data_o is combinational from the array and head; valid every cycle, sampled by the consumer only when arch_fl_rec_o = 1.
- Reset asserted mid-recovery: the FSM returns to IDLE immediately and the pulse is dropped.

Decomposition:
- Shared package rename_pkg:
  - constants NUM_PHYS_REGS=80, NUM_ARCH_REGS=32, FL_DEPTH=48, PRD_W=7, RET_W=4;
  - type prd_t [6:0];
  - function ptr_add_mod48(ptr, inc).
- Sub-module arch_rfl_mem: 48x7 array with 4 indexed read ports for the checks, 4 write ports, and a rotated 336-bit dump port driven by head.
- Top level holds the pointer, prefix-count logic, release pipeline register and FSM.

Test Plan:
- Reset, no traffic -> rec data slice0=32, slice47=79; fl_err_o=0; rls*_vld_o=0.
- Slot0 retire new=32 old=5 -> next cycle rls0_rd_o=5 vld=1; head=1; entry0=5; fl_err_o stays 0.
- Slots 1 and 3 active (new=32,33; old=7,9) from head 0 -> entries 0,1 = 7,9; head=2; rls1=7, rls3=9 valid; rls0/rls2 vld=0.
- Head=46, four active slots -> writes to entries 46,47,0,1; head=2 (wrap correct).
- Slot0 new=40 while mem[head]=32 -> fl_err_o=1 next edge and remains 1 afterwards.
- flush_i with slot0 retire (old=12) at head 0 -> next cycle arch_fl_rec_o=1 for one cycle, slice47=12, slice0=33; retire_vld during REC causes no head change.
